// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall-vector encodings for the pipeline sequencer.
// Stall vector bit order: {WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}, bit0 = PC.
package pipe_ctrl_pkg;

    typedef logic [5:0] stall_vec_t;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } ctrl_state_t;

    localparam stall_vec_t STALL_NONE     = 6'b000000;
    localparam stall_vec_t STALL_FROM_IF  = 6'b000011;
    localparam stall_vec_t STALL_FROM_ID  = 6'b000111;
    localparam stall_vec_t STALL_FROM_EX  = 6'b001111;
    localparam stall_vec_t STALL_FROM_MEM = 6'b011111;

    // Deepest requester wins; a load-use hazard stalls like an ID request.
    function automatic stall_vec_t stall_encode(
        input logic if_req,
        input logic id_req,
        input logic ex_req,
        input logic mem_req
    );
        if (mem_req)     return STALL_FROM_MEM;
        else if (ex_req) return STALL_FROM_EX;
        else if (id_req) return STALL_FROM_ID;
        else if (if_req) return STALL_FROM_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_loaduse_detect.sv
// Load-use hazard compare: a load in EX writing a register that ID is reading.
// Purely combinational so the forwarding logic can reuse it.
module loaduse_detect (
    input  logic       ex_is_load,
    input  logic       ex_wreg_en,
    input  logic [4:0] ex_wreg_addr,
    input  logic       id_r1_en,
    input  logic [4:0] id_r1_addr,
    input  logic       id_r2_en,
    input  logic [4:0] id_r2_addr,
    output logic       hazard
);

    logic r1_match;
    logic r2_match;

    assign r1_match = id_r1_en && (id_r1_addr == ex_wreg_addr);
    assign r2_match = id_r2_en && (id_r2_addr == ex_wreg_addr);

    // $zero is never a real dependency.
    assign hazard = ex_is_load && ex_wreg_en && (ex_wreg_addr != 5'd0) && (r1_match || r2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector, multi-cycle flush, delay-slot flag, stall watchdog.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stallreq,
    input  logic        id_stallreq,
    input  logic        ex_stallreq,
    input  logic        mem_stallreq,
    input  logic        ex_is_load,
    input  logic        ex_wreg_en,
    input  logic [4:0]  ex_wreg_addr,
    input  logic        id_r1_en,
    input  logic [4:0]  id_r1_addr,
    input  logic        id_r2_en,
    input  logic [4:0]  id_r2_addr,
    input  logic        id_next_in_delayslot,
    input  logic        flush_req,
    input  logic [31:0] flush_pc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc_o,
    output logic        id_in_delayslot_o,
    output logic        loaduse_hazard,
    output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_loaduse_cycles
`endif
);

    import pipe_ctrl_pkg::*;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES);
    localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

    ctrl_state_t state_reg, state_next;
    logic [2:0]  flush_cnt_reg, flush_cnt_next;
    logic [7:0]  stall_cnt_reg, stall_cnt_next;
    logic [7:0]  stall_cnt_inc;
    logic [31:0] flush_pc_reg;
    logic        ds_reg;
    logic        timeout_reg;
    stall_vec_t  stall_req_vec;
    stall_vec_t  stall_vec;

    loaduse_detect u_loaduse (
        .ex_is_load   (ex_is_load),
        .ex_wreg_en   (ex_wreg_en),
        .ex_wreg_addr (ex_wreg_addr),
        .id_r1_en     (id_r1_en),
        .id_r1_addr   (id_r1_addr),
        .id_r2_en     (id_r2_en),
        .id_r2_addr   (id_r2_addr),
        .hazard       (loaduse_hazard)
    );

    assign stall_req_vec = stall_encode(if_stallreq, id_stallreq || loaduse_hazard,
                                        ex_stallreq, mem_stallreq);
    assign stall_cnt_inc = (stall_cnt_reg == 8'hFF) ? 8'hFF : stall_cnt_reg + 8'd1;

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        stall_vec      = stall_req_vec;
        case (state_reg)
            RUN, STALL: begin
                if (flush_req) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                    stall_cnt_next = 8'd0;
                    stall_vec      = STALL_NONE;
                end else if (stall_req_vec != STALL_NONE) begin
                    state_next     = STALL;
                    stall_cnt_next = stall_cnt_inc;
                end else begin
                    state_next     = RUN;
                    stall_cnt_next = 8'd0;
                end
            end
            FLUSH: begin
                // Stall requests are ignored here and re-sampled in the first RUN cycle.
                stall_vec = STALL_NONE;
                if (flush_req) begin
                    flush_cnt_next = FLUSH_LOAD;
                end else if (flush_cnt_reg <= 3'd1) begin
                    state_next     = RUN;
                    flush_cnt_next = 3'd0;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next     = RUN;
                flush_cnt_next = 3'd0;
                stall_cnt_next = 8'd0;
            end
        endcase
        if (rst) begin
            stall_vec = STALL_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            flush_cnt_reg <= 3'd0;
            stall_cnt_reg <= 8'd0;
            flush_pc_reg  <= 32'd0;
            ds_reg        <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            if (flush_req) begin
                flush_pc_reg <= flush_pc_i;
            end
            // Clearing on entry as well keeps the flag low for every flush cycle.
            if (state_next == FLUSH || state_reg == FLUSH) begin
                ds_reg <= 1'b0;
            end else if (!stall_vec[1]) begin
                ds_reg <= id_next_in_delayslot;
            end
            // Sets on the edge that closes the MAX_STALL-th consecutive stall cycle.
            if (stall_vec != STALL_NONE && stall_cnt_next == STALL_LIMIT) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign stall             = stall_vec;
    assign flush             = (state_reg == FLUSH);
    assign flush_pc_o        = flush_pc_reg;
    assign id_in_delayslot_o = ds_reg;
    assign stall_timeout     = timeout_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_loaduse_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_reg   <= 32'd0;
            perf_loaduse_reg <= 32'd0;
        end else begin
            if (stall_vec != STALL_NONE) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (loaduse_hazard) begin
                perf_loaduse_reg <= perf_loaduse_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cycles   = perf_stall_reg;
    assign perf_loaduse_cycles = perf_loaduse_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a cycle-count model of the sequencer.
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int MS = 64;

    logic        clk;
    logic        rst;
    logic        if_stallreq, id_stallreq, ex_stallreq, mem_stallreq;
    logic        ex_is_load, ex_wreg_en;
    logic [4:0]  ex_wreg_addr;
    logic        id_r1_en, id_r2_en;
    logic [4:0]  id_r1_addr, id_r2_addr;
    logic        id_next_in_delayslot;
    logic        flush_req;
    logic [31:0] flush_pc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc_o;
    logic        id_in_delayslot_o;
    logic        loaduse_hazard;
    logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_loaduse_cycles;
`endif

    pipe_ctrl #(.FLUSH_CYCLES(FC), .MAX_STALL(MS)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_stallreq          (if_stallreq),
        .id_stallreq          (id_stallreq),
        .ex_stallreq          (ex_stallreq),
        .mem_stallreq         (mem_stallreq),
        .ex_is_load           (ex_is_load),
        .ex_wreg_en           (ex_wreg_en),
        .ex_wreg_addr         (ex_wreg_addr),
        .id_r1_en             (id_r1_en),
        .id_r1_addr           (id_r1_addr),
        .id_r2_en             (id_r2_en),
        .id_r2_addr           (id_r2_addr),
        .id_next_in_delayslot (id_next_in_delayslot),
        .flush_req            (flush_req),
        .flush_pc_i           (flush_pc_i),
        .stall                (stall),
        .flush                (flush),
        .flush_pc_o           (flush_pc_o),
        .id_in_delayslot_o    (id_in_delayslot_o),
        .loaduse_hazard       (loaduse_hazard),
        .stall_timeout        (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles    (perf_stall_cycles),
        .perf_loaduse_cycles  (perf_loaduse_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: remaining flush cycles, consecutive stall cycles, latched flags.
    int          m_flush_left;
    int          m_run;
    bit          m_to;
    bit          m_ds;
    logic [31:0] m_pc;
    logic [31:0] m_ps;
    logic [31:0] m_pl;
    logic [5:0]  m_stall;
    bit          m_hz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_run = 0;
        m_to = 0;
        m_ds = 0;
        m_pc = 32'd0;
        m_ps = 32'd0;
        m_pl = 32'd0;
    endtask

    // Negedge: derive expected outputs from current inputs and model state, compare.
    task automatic settle();
        logic [5:0] req;
        @(negedge clk);
        m_hz = ex_is_load && ex_wreg_en && ex_wreg_addr != 0 &&
               ((id_r1_en && id_r1_addr == ex_wreg_addr) || (id_r2_en && id_r2_addr == ex_wreg_addr));
        if (mem_stallreq)               req = 6'b011111;
        else if (ex_stallreq)           req = 6'b001111;
        else if (id_stallreq || m_hz)   req = 6'b000111;
        else if (if_stallreq)           req = 6'b000011;
        else                            req = 6'b000000;
        m_stall = (rst || m_flush_left > 0 || flush_req) ? 6'b0 : req;
        chk("loaduse", 32'(loaduse_hazard), 32'(m_hz));
        chk("stall", 32'(stall), 32'(m_stall));
        chk("flush", 32'(flush), 32'(m_flush_left > 0));
        chk("flush_pc", flush_pc_o, m_pc);
        chk("delayslot", 32'(id_in_delayslot_o), 32'(m_ds));
        chk("timeout", 32'(stall_timeout), 32'(m_to));
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", perf_stall_cycles, m_ps);
        chk("perf_loaduse", perf_loaduse_cycles, m_pl);
`endif
    endtask

    // Posedge: advance the model with the inputs that were just sampled.
    task automatic edge_step();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (flush_req || m_flush_left > 0) m_ds = 0;
            else if (!m_stall[1])              m_ds = id_next_in_delayslot;
            if (flush_req) begin
                m_flush_left = FC;
                m_pc = flush_pc_i;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
            if (m_stall != 0) begin
                m_run = (m_run >= 255) ? 255 : m_run + 1;
                if (m_run == MS) m_to = 1;
                m_ps = m_ps + 1;
            end else begin
                m_run = 0;
            end
            if (m_hz) m_pl = m_pl + 1;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        edge_step();
    endtask

    task automatic idle_inputs();
        if_stallreq = 0; id_stallreq = 0; ex_stallreq = 0; mem_stallreq = 0;
        ex_is_load = 0; ex_wreg_en = 0; ex_wreg_addr = 0;
        id_r1_en = 0; id_r1_addr = 0; id_r2_en = 0; id_r2_addr = 0;
        id_next_in_delayslot = 0; flush_req = 0; flush_pc_i = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();

        // Reset values.
        settle();
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_pc", flush_pc_o, 32'h0);
        chk("rst_to", 32'(stall_timeout), 32'h0);
        edge_step();
        rst = 0;
        cyc();
        $display("phase reset done");

        // LW $t0 in EX, ID reads r8.
        ex_is_load = 1; ex_wreg_en = 1; ex_wreg_addr = 8; id_r1_en = 1; id_r1_addr = 8;
        settle();
        chk("lu_hz", 32'(loaduse_hazard), 32'h1);
        chk("lu_stall", 32'(stall), 32'h07);
        edge_step();
        ex_is_load = 0;
        settle();
        chk("lu_release", 32'(stall), 32'h0);
        edge_step();
        ex_is_load = 1; ex_wreg_addr = 0; id_r1_addr = 0;
        settle();
        chk("lu_zero_hz", 32'(loaduse_hazard), 32'h0);
        chk("lu_zero_stall", 32'(stall), 32'h0);
        edge_step();
        idle_inputs();
        $display("phase loaduse done");

        // MEM and ID together for three cycles.
        mem_stallreq = 1; id_stallreq = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("memid_stall", 32'(stall), 32'h1F);
            edge_step();
        end
        idle_inputs();
        settle();
        chk("memid_run", 32'(stall), 32'h0);
        edge_step();
        $display("phase mem+id done");

        // Flush during an EX stall.
        ex_stallreq = 1;
        settle();
        chk("ex_stall", 32'(stall), 32'h0F);
        edge_step();
        flush_req = 1; flush_pc_i = 32'hBFC0_0380; id_next_in_delayslot = 1;
        settle();
        chk("flreq_stall", 32'(stall), 32'h0);
        edge_step();
        flush_req = 0;
        for (int i = 0; i < FC; i++) begin
            settle();
            chk("fl_flush", 32'(flush), 32'h1);
            chk("fl_stall", 32'(stall), 32'h0);
            chk("fl_pc", flush_pc_o, 32'hBFC0_0380);
            chk("fl_ds", 32'(id_in_delayslot_o), 32'h0);
            edge_step();
        end
        settle();
        chk("fl_end", 32'(flush), 32'h0);
        chk("fl_restall", 32'(stall), 32'h0F);
        edge_step();
        idle_inputs();
        cyc();
        $display("phase flush done");

        // Delay-slot flag held across an IF stall.
        id_next_in_delayslot = 1; if_stallreq = 1;
        settle();
        chk("ds_ifstall", 32'(stall), 32'h03);
        chk("ds_before", 32'(id_in_delayslot_o), 32'h0);
        edge_step();
        settle();
        chk("ds_held", 32'(id_in_delayslot_o), 32'h0);
        edge_step();
        if_stallreq = 0;
        cyc();
        settle();
        chk("ds_set", 32'(id_in_delayslot_o), 32'h1);
        edge_step();
        idle_inputs();
        cyc();
        $display("phase delayslot done");

        // Watchdog: 70 EX stall cycles.
        ex_stallreq = 1;
        for (int i = 1; i <= 70; i++) begin
            settle();
            if (i == MS) chk("to_before", 32'(stall_timeout), 32'h0);
            if (i == MS + 1) chk("to_after", 32'(stall_timeout), 32'h1);
            edge_step();
        end
        ex_stallreq = 0;
        settle();
        chk("to_sticky", 32'(stall_timeout), 32'h1);
        edge_step();
        rst = 1;
        cyc();
        rst = 0;
        settle();
        chk("to_cleared", 32'(stall_timeout), 32'h0);
        edge_step();
        $display("phase timeout done");

`ifdef PIPE_CTRL_PERF_EN
        rst = 1;
        cyc();
        rst = 0;
        ex_is_load = 1; ex_wreg_en = 1; ex_wreg_addr = 9; id_r2_en = 1; id_r2_addr = 9;
        for (int i = 0; i < 5; i++) cyc();
        idle_inputs();
        mem_stallreq = 1;
        for (int i = 0; i < 3; i++) cyc();
        mem_stallreq = 0;
        settle();
        chk("perf_stall_lit", perf_stall_cycles, 32'd8);
        chk("perf_lu_lit", perf_loaduse_cycles, 32'd5);
        edge_step();
        $display("phase perf done");
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst                  = ($urandom_range(0, 199) == 0);
            flush_req            = ($urandom_range(0, 24) == 0);
            flush_pc_i           = $urandom;
            if_stallreq          = ($urandom_range(0, 5) == 0);
            id_stallreq          = ($urandom_range(0, 7) == 0);
            ex_stallreq          = ($urandom_range(0, 9) == 0);
            mem_stallreq         = ($urandom_range(0, 11) == 0);
            ex_is_load           = ($urandom_range(0, 2) == 0);
            ex_wreg_en           = ($urandom_range(0, 3) != 0);
            ex_wreg_addr         = 5'($urandom_range(0, 3));
            id_r1_en             = $urandom_range(0, 1) != 0;
            id_r1_addr           = 5'($urandom_range(0, 3));
            id_r2_en             = $urandom_range(0, 1) != 0;
            id_r2_addr           = 5'($urandom_range(0, 3));
            id_next_in_delayslot = $urandom_range(0, 1) != 0;
            cyc();
        end
        idle_inputs();
        rst = 0;
        cyc();
        $display("phase random done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Merges stall requests from IF/ID/EX/MEM with a load-use hazard it detects itself, and produces the per-register stall vector.
- Sequences multi-cycle flushes (exception/redirect) and owns the ID delay-slot flag register.
- Sits beside the pipeline registers; every stage register and the PC consume its outputs.

Parameters:
- FLUSH_CYCLES, 1: cycles `flush` is held asserted per flush event (1..7).
- MAX_STALL, 64: consecutive stall cycles before `stall_timeout` sets (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_stallreq  in  1  IF stall request
- id_stallreq  in  1  ID stall request
- ex_stallreq  in  1  EX stall request (multi-cycle op)
- mem_stallreq  in  1  MEM stall request (bus wait)
- ex_is_load  in  1  instruction in EX is LB/LW
- ex_wreg_en  in  1  EX destination write enable
- ex_wreg_addr  in  5  EX destination register
- id_r1_en / id_r1_addr  in  1 / 5  ID source 1 read
- id_r2_en / id_r2_addr  in  1 / 5  ID source 2 read
- id_next_in_delayslot  in  1  ID holds a taken jump/branch
- flush_req  in  1  single-cycle flush request
- flush_pc_i  in  32  redirect target for the flush
- stall  out  6  {WB,MEM/WB,EX/MEM,ID/EX,IF/ID,PC} hold vector, bit0 = PC
- flush  out  1  clear all pipeline registers
- flush_pc_o  out  32  latched redirect target, valid while `flush`
- id_in_delayslot_o  out  1  instruction now in ID is a delay slot
- loaduse_hazard  out  1  load-use hazard detected this cycle
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, active-high): state = RUN, counters = 0, `stall` = 0, `flush` = 0, `flush_pc_o` = 0, `id_in_delayslot_o` = 0, `stall_timeout` = 0.
- Load-use hazard (combinational): `ex_is_load & ex_wreg_en & ex_wreg_addr != 0 & ((id_r1_en & id_r1_addr == ex_wreg_addr) | (id_r2_en & id_r2_addr == ex_wreg_addr))`.
- Stall vector, combinational, highest priority first:
  - `mem_stallreq` → 6'b011111
  - `ex_stallreq` → 6'b001111
  - `id_stallreq` or load-use → 6'b000111
  - `if_stallreq` → 6'b000011
  - otherwise → 0
- State RUN:
  - `flush_req` → FLUSH. Latch `flush_pc_i`, load the flush counter with FLUSH_CYCLES. Flush beats stall: `stall` is forced to 0 in the request cycle and throughout FLUSH.
  - Else a nonzero stall vector → STALL, and the stall counter increments.
- State STALL:
  - Stall vector stays nonzero: remain, counter increments and saturates at 255.
  - Counter reaches MAX_STALL: `stall_timeout` sets (sticky until rst).
  - Stall vector zero: → RUN, counter cleared.
  - `flush_req` → FLUSH; stall is dropped immediately.
- State FLUSH:
  - `flush` = 1 and `stall` = 0 for exactly FLUSH_CYCLES cycles, starting the cycle after `flush_req`, then → RUN.
  - A new `flush_req` during FLUSH relatches the PC and reloads the counter.
- Delay-slot flag:
  - `id_in_delayslot_o` <= `id_next_in_delayslot` when `stall[1]` = 0.
  - Holds its value when `stall[1]` = 1.
  - Cleared on any cycle `flush` = 1.
- Simultaneous `flush_req` and `rst`: rst wins.
- Stall requests arriving during FLUSH are ignored; they are re-evaluated on the first RUN cycle.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - Two 32-bit wrapping counters, `perf_stall_cycles` and `perf_loaduse_cycles`, exposed as additional outputs.
  - They count cycles with `stall` != 0 and cycles with `loaduse_hazard` = 1.
  - Cleared by rst.
- Undefined: ports and logic absent; the rest of the block is unchanged.

Decomposition:
- project_types gains:
  - `stall_vec_t` (6-bit)
  - `ctrl_state_t` enum {RUN, STALL, FLUSH}
  - constants STALL_NONE, STALL_FROM_IF, STALL_FROM_ID, STALL_FROM_EX, STALL_FROM_MEM (the encodings above)
- Sub-module `loaduse_detect`: pure combinational compare, reused later by the forwarding logic.

Test Plan:
- LW $t0 in EX (`ex_wreg_addr` = 8) while ID reads r1 = 8 → `loaduse_hazard` = 1, `stall` = 6'b000111 for 1 cycle; same stimulus with `ex_wreg_addr` = 0 → no stall.
- `mem_stallreq` and `id_stallreq` together for 3 cycles → `stall` = 6'b011111 for all 3 cycles; state returns to RUN on cycle 4.
- `flush_req` with `flush_pc_i` = 0xBFC0_0380 during an active EX stall, FLUSH_CYCLES = 2:
  - next 2 cycles: `flush` = 1, `stall` = 0, `flush_pc_o` = 0xBFC0_0380
  - `id_in_delayslot_o` = 0
- `id_next_in_delayslot` = 1 with `if_stallreq` = 1 → `id_in_delayslot_o` unchanged; after the stall releases it becomes 1 the next cycle.
- `ex_stallreq` held 70 cycles, MAX_STALL = 64 → `stall_timeout` rises at stall cycle 64 and stays 1 after release; rst clears it.
- With PIPE_CTRL_PERF_EN: 5 load-use cycles plus 3 mem stalls → `perf_stall_cycles` = 8, `perf_loaduse_cycles` = 5.
